deser_param: RTL and testbench

- Parametrised serial-to-parallel converter, the next generation of the team's 8-bit deserializer.
- Accepts one bit per cycle while write_in is high and assembles words of WIDTH bits, LSB-first or MSB-first.
- Completed words go into an internal OUT_DEPTH-entry queue, so reception continues while the consumer (stack side of the design) has not yet acknowledged.
- Consumer side uses a data_ready/ack_in handshake.

---
 rtl/deser_pkg.sv | 20 ++
 rtl/deser_param_if.sv | 36 +++
 rtl/deser_word_fifo.sv | 65 ++++++
 rtl/deser_param.sv | 118 +++++++++++
 tb/tb_deser_param.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/deser_pkg.sv
// Shared state encoding and width helpers for the parametrised deserializer.
package deser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    // Bits needed to count 0..width-1 received bits.
    function automatic int unsigned cnt_bits(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    // Bits needed to hold an occupancy of 0..depth.
    function automatic int unsigned occ_bits(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/deser_param_if.sv
// Serial-in / word-out bus of the deserializer; parity_err exists only
// when DESER_PARITY_EN is defined.
interface deser_param_if #(
    parameter int unsigned WIDTH = 8
);
    logic             data_in;
    logic             write_in;
    logic             flush_in;
    logic             ack_in;
    logic [WIDTH-1:0] data_out;
    logic             data_ready;
    logic             status_out;

`ifdef DESER_PARITY_EN
    logic             parity_err;

    modport master (
        output data_in, write_in, flush_in, ack_in,
        input  data_out, data_ready, status_out, parity_err
    );
    modport slave (
        input  data_in, write_in, flush_in, ack_in,
        output data_out, data_ready, status_out, parity_err
    );
`else
    modport master (
        output data_in, write_in, flush_in, ack_in,
        input  data_out, data_ready, status_out
    );
    modport slave (
        input  data_in, write_in, flush_in, ack_in,
        output data_out, data_ready, status_out
    );
`endif

endinterface

// File: rtl/deser_word_fifo.sv
// Circular buffer of completed words; head is the oldest entry.
module deser_word_fifo
    import deser_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned OUT_DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned OW = occ_bits(OUT_DEPTH);
    localparam int unsigned PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(OUT_DEPTH - 1);

    logic [WIDTH-1:0] mem [OUT_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [OW-1:0]    occ;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign head  = mem[rd_ptr];
    assign full  = (occ == OW'(OUT_DEPTH));
    assign empty = (occ == '0);

    // Caller never pushes while full, so push+pop leaves occupancy unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < int'(OUT_DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push && !pop) begin
                occ <= occ + OW'(1);
            end else if (pop && !push) begin
                occ <= occ - OW'(1);
            end
        end
    end

endmodule

// File: rtl/deser_param.sv
// Parametrised serial-to-parallel converter with an output word queue.
// Optional even-parity framing is enabled by defining DESER_PARITY_EN.
module deser_param
    import deser_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b1,
    parameter int unsigned OUT_DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    deser_param_if.slave  bus
);

    localparam int unsigned  CW       = cnt_bits(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] word_next;
    logic [WIDTH-1:0] push_word;
    logic [WIDTH-1:0] head;
    logic [CW-1:0]    pos;
    logic             accept;
    logic             last_bit;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
`ifdef DESER_PARITY_EN
    logic             parity_ok;
    logic             parity_err_q;
`endif

    always_comb begin
        pos       = LSB_FIRST ? bit_cnt : (LAST_BIT - bit_cnt);
        word_next = shreg;
        word_next[pos] = bus.data_in;
        accept    = bus.write_in & ~full & ~bus.flush_in;
        last_bit  = (state != PARITY) && (bit_cnt == LAST_BIT);
        pop       = bus.ack_in & ~empty & ~bus.flush_in;
`ifdef DESER_PARITY_EN
        parity_ok = ~(^{shreg, bus.data_in});
        push      = accept & (state == PARITY) & parity_ok;
        push_word = shreg;
`else
        push      = accept & last_bit;
        push_word = word_next;
`endif
    end

    // Input-side state machine; flush outranks any accepted bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
`ifdef DESER_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
`ifdef DESER_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            if (bus.flush_in) begin
                state   <= IDLE;
                bit_cnt <= '0;
                shreg   <= '0;
            end else if (accept) begin
`ifdef DESER_PARITY_EN
                if (state == PARITY) begin
                    state        <= IDLE;
                    shreg        <= '0;
                    parity_err_q <= ~parity_ok;
                end else
`endif
                if (last_bit) begin
                    bit_cnt <= '0;
`ifdef DESER_PARITY_EN
                    state   <= PARITY;
                    shreg   <= word_next;
`else
                    state   <= IDLE;
                    shreg   <= '0;
`endif
                end else begin
                    bit_cnt <= bit_cnt + CW'(1);
                    state   <= SHIFT;
                    shreg   <= word_next;
                end
            end
        end
    end

    deser_word_fifo #(
        .WIDTH     (WIDTH),
        .OUT_DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (bus.flush_in),
        .push_data (push_word),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    assign bus.data_out   = head;
    assign bus.data_ready = ~empty;
    assign bus.status_out = ~full;
`ifdef DESER_PARITY_EN
    assign bus.parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_deser_param.sv
// Bench for deser_param: two configurations checked every cycle against a
// queue-level model, plus directed literal checks.
module tb_deser_param;

    localparam int unsigned W0 = 8;
    localparam int unsigned D0 = 2;
    localparam bit          L0 = 1'b1;
    localparam int unsigned W1 = 12;
    localparam int unsigned D1 = 1;
    localparam bit          L1 = 1'b0;
    localparam int          NI = 2;
`ifdef DESER_PARITY_EN
    localparam int          PB = 1;
`else
    localparam int          PB = 0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic d_in [NI];
    logic wr   [NI];
    logic fl   [NI];
    logic ak   [NI];

    logic [31:0] mq [NI][8];
    int          mcnt [NI];
    bit          mb [NI][16];
    int          mn [NI];
    bit          mperr [NI];

    int tests = 0;
    int fails = 0;

    deser_param_if #(.WIDTH(W0)) bus0 ();
    deser_param_if #(.WIDTH(W1)) bus1 ();

    assign bus0.data_in  = d_in[0];
    assign bus0.write_in = wr[0];
    assign bus0.flush_in = fl[0];
    assign bus0.ack_in   = ak[0];
    assign bus1.data_in  = d_in[1];
    assign bus1.write_in = wr[1];
    assign bus1.flush_in = fl[1];
    assign bus1.ack_in   = ak[1];

    deser_param #(.WIDTH(W0), .LSB_FIRST(L0), .OUT_DEPTH(D0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0));
    deser_param #(.WIDTH(W1), .LSB_FIRST(L1), .OUT_DEPTH(D1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1));

    always #5 clk = ~clk;

    function automatic int cw(input int i);  return (i == 0) ? int'(W0) : int'(W1); endfunction
    function automatic int cd(input int i);  return (i == 0) ? int'(D0) : int'(D1); endfunction
    function automatic bit cl(input int i);  return (i == 0) ? L0 : L1;              endfunction

    function automatic logic [31:0] dout(input int i);
        return (i == 0) ? 32'(bus0.data_out) : 32'(bus1.data_out);
    endfunction
    function automatic logic dready(input int i);
        return (i == 0) ? bus0.data_ready : bus1.data_ready;
    endfunction
    function automatic logic dstat(input int i);
        return (i == 0) ? bus0.status_out : bus1.status_out;
    endfunction
`ifdef DESER_PARITY_EN
    function automatic logic dperr(input int i);
        return (i == 0) ? bus0.parity_err : bus1.parity_err;
    endfunction
`endif

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Frame-level model: collect bits, assemble a word when a frame is complete.
    task automatic model_step(input int i);
        bit          full;
        bit          do_pop;
        bit          do_push;
        bit          par;
        logic [31:0] w;
        int          pos;
        mperr[i] = 1'b0;
        if (fl[i]) begin
            mcnt[i] = 0;
            mn[i]   = 0;
            return;
        end
        full    = (mcnt[i] == cd(i));
        do_pop  = ak[i] && (mcnt[i] > 0);
        do_push = 1'b0;
        w       = '0;
        if (wr[i] && !full) begin
            mb[i][mn[i]] = d_in[i];
            mn[i]++;
            if (mn[i] == cw(i) + PB) begin
                par = 1'b0;
                for (int k = 0; k < mn[i]; k++) par ^= mb[i][k];
                for (int k = 0; k < cw(i); k++) begin
                    pos    = cl(i) ? k : cw(i) - 1 - k;
                    w[pos] = mb[i][k];
                end
                do_push = (PB == 0) || !par;
                mperr[i] = (PB != 0) && par;
                mn[i] = 0;
            end
        end
        if (do_pop) begin
            for (int k = 0; k < 7; k++) mq[i][k] = mq[i][k+1];
            mcnt[i]--;
        end
        if (do_push) begin
            mq[i][mcnt[i]] = w;
            mcnt[i]++;
        end
    endtask

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < NI; i++) begin
            if (reset) begin
                mcnt[i] = 0; mn[i] = 0; mperr[i] = 1'b0;
            end else begin
                model_step(i);
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            cmp($sformatf("i%0d_ready", i), 32'(dready(i)), 32'(mcnt[i] > 0));
            cmp($sformatf("i%0d_status", i), 32'(dstat(i)), 32'(mcnt[i] < cd(i)));
            if (mcnt[i] > 0) cmp($sformatf("i%0d_data", i), dout(i), mq[i][0]);
`ifdef DESER_PARITY_EN
            cmp($sformatf("i%0d_perr", i), 32'(dperr(i)), 32'(mperr[i]));
`endif
        end
    end

    task automatic cyc(input int i, input bit w, input bit d, input bit f, input bit a);
        @(negedge clk);
        for (int j = 0; j < NI; j++) begin
            wr[j] = 1'b0; fl[j] = 1'b0; ak[j] = 1'b0; d_in[j] = 1'b0;
        end
        wr[i] = w; d_in[i] = d; fl[i] = f; ak[i] = a;
    endtask

    task automatic idle(input int i);
        cyc(i, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_bits(input int i, input logic [31:0] bits, input int n);
        for (int k = 0; k < n; k++) cyc(i, 1'b1, bits[k], 1'b0, 1'b0);
    endtask

    initial begin
        for (int j = 0; j < NI; j++) begin
            wr[j] = 1'b0; fl[j] = 1'b0; ak[j] = 1'b0; d_in[j] = 1'b0;
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NI; i++) begin
            cmp("rst_ready", 32'(dready(i)), 32'h0);
            cmp("rst_status", 32'(dstat(i)), 32'h1);
            cmp("rst_data", dout(i), 32'h0);
        end

`ifdef DESER_PARITY_EN
        send_bits(0, 32'h003, 9);
        idle(0);
        cmp("par_ok_ready", 32'(dready(0)), 32'h1);
        cmp("par_ok_data", dout(0), 32'h03);
        cmp("par_ok_err", 32'(dperr(0)), 32'h0);
        cyc(0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(0);
        send_bits(0, 32'h103, 9);
        idle(0);
        cmp("par_bad_ready", 32'(dready(0)), 32'h0);
        cmp("par_bad_err", 32'(dperr(0)), 32'h1);
        idle(0);
        cmp("par_err_pulse", 32'(dperr(0)), 32'h0);
`else
        send_bits(0, 32'h03, 7);
        cyc(0, 1'b1, 1'b0, 1'b0, 1'b0);
        cmp("ready_before_last", 32'(dready(0)), 32'h0);
        idle(0);
        cmp("w03_ready", 32'(dready(0)), 32'h1);
        cmp("w03_data", dout(0), 32'h03);
        cyc(0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(0);
        cmp("ack_ready", 32'(dready(0)), 32'h0);

        send_bits(0, 32'h11, 8);
        send_bits(0, 32'h22, 8);
        idle(0);
        cmp("full_status", 32'(dstat(0)), 32'h0);
        cmp("full_head", dout(0), 32'h11);
        send_bits(0, 32'h07, 3);
        cyc(0, 1'b0, 1'b0, 1'b0, 1'b1);
        cmp("full_ack_status", 32'(dstat(0)), 32'h0);
        idle(0);
        cmp("after_ack_status", 32'(dstat(0)), 32'h1);
        cmp("after_ack_head", dout(0), 32'h22);
        send_bits(0, 32'h33, 8);
        idle(0);
        cmp("q33_head", dout(0), 32'h22);
        cyc(0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(0);
        cmp("q33_next", dout(0), 32'h33);

        send_bits(0, 32'h44, 7);
        cyc(0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(0);
        cmp("pushpop_data", dout(0), 32'h44);
        cmp("pushpop_ready", 32'(dready(0)), 32'h1);
        cmp("pushpop_status", 32'(dstat(0)), 32'h1);

        send_bits(0, 32'h1F, 5);
        cyc(0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(0);
        cmp("flush_ready", 32'(dready(0)), 32'h0);
        cmp("flush_status", 32'(dstat(0)), 32'h1);
        send_bits(0, 32'hA5, 8);
        idle(0);
        cmp("wA5_data", dout(0), 32'hA5);

        send_bits(0, 32'h05, 4);
        #2 reset = 1'b1;
        #1;
        cmp("arst_ready", 32'(dready(0)), 32'h0);
        cmp("arst_status", 32'(dstat(0)), 32'h1);
        cmp("arst_data", dout(0), 32'h0);
        idle(0);
        reset = 1'b0;
        send_bits(0, 32'h96, 8);
        idle(0);
        cmp("w96_data", dout(0), 32'h96);

        send_bits(1, 32'hFFF, 12);
        idle(1);
        cmp("wFFF_data", dout(1), 32'hFFF);
        cmp("wFFF_status", 32'(dstat(1)), 32'h0);
        send_bits(1, 32'h3, 2);
        cyc(1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
        cmp("d1_empty", 32'(dready(1)), 32'h0);
        send_bits(1, 32'h003, 12);
        idle(1);
        cmp("wC00_data", dout(1), 32'hC00);
        cyc(1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
`endif

        repeat (3000) begin
            @(negedge clk);
            for (int j = 0; j < NI; j++) begin
                wr[j]   = ($urandom_range(9) < 7);
                d_in[j] = 1'($urandom_range(1));
                ak[j]   = ($urandom_range(9) < 3);
                fl[j]   = ($urandom_range(49) == 0);
            end
        end
        idle(0);
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
